// File: rtl/row_scan_decoder.sv
// row_scan_decoder: registered one-hot row select with direct decode and
// a wrapping scan counter over COUNT positions (N-bit select, 2**N rows).
//
// Ports:
//   clk   - sole clock, rising edge
//   rst   - synchronous active-high reset
//   ena   - output enable; 0 forces out to zero and freezes index
//   mode  - 0 = direct decode of in, 1 = scan
//   in    - direct select / scan load value
//   load  - scan load strobe (wins over step)
//   step  - scan advance strobe
//   out   - registered one-hot (or all-zero) row select
//   index - registered current position
//   wrap  - one-cycle pulse when the scan wraps COUNT-1 -> 0
//
// Optional feature: define ROW_SCAN_DECODER_BLANKING_EN to insert a
// one-cycle break-before-make blank on every scan step.

module row_scan_decoder #(
    parameter int N     = 3,
    parameter int COUNT = 2**N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              mode,
    input  logic [N-1:0]      in,
    input  logic              load,
    input  logic              step,
    output logic [2**N-1:0]   out,
    output logic [N-1:0]      index,
    output logic              wrap
);

`ifdef ROW_SCAN_DECODER_BLANKING_EN
    localparam logic BLANK_EN = 1'b1;
`else
    localparam logic BLANK_EN = 1'b0;
`endif

    // Compare in N+1 bits so COUNT == 2**N is representable.
    localparam int       LAST_I = COUNT - 1;
    localparam logic [N:0] CNT  = COUNT[N:0];
    localparam logic [N:0] LAST = LAST_I[N:0];

    function automatic logic [2**N-1:0] dec(input logic [N-1:0] s);
        logic [2**N-1:0] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

    logic         blank_q;
    logic         at_last;
    logic         step_ok;
    logic [N-1:0] load_idx;
    logic [N-1:0] step_idx;

    // index >= COUNT-1 also covers out-of-range values left by direct mode.
    assign at_last  = ({1'b0, index} >= LAST);
    assign load_idx = ({1'b0, in} < CNT) ? in : '0;
    assign step_idx = at_last ? '0 : index + 1'b1;
    // A step during the blank cycle is dropped, not queued.
    assign step_ok  = step & ~(BLANK_EN & blank_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            index   <= '0;
            out     <= '0;
            wrap    <= 1'b0;
            blank_q <= 1'b0;
        end else if (!ena) begin
            out     <= '0;
            wrap    <= 1'b0;
            blank_q <= 1'b0;
        end else if (!mode) begin
            index   <= in;
            out     <= dec(in);
            wrap    <= 1'b0;
            blank_q <= 1'b0;
        end else if (load) begin
            index   <= load_idx;
            out     <= dec(load_idx);
            wrap    <= 1'b0;
            blank_q <= 1'b0;
        end else if (step_ok) begin
            index   <= step_idx;
            wrap    <= at_last;
            out     <= BLANK_EN ? '0 : dec(step_idx);
            blank_q <= BLANK_EN;
        end else begin
            // Hold; also ends a blank and restores out after ena returns.
            out     <= dec(index);
            wrap    <= 1'b0;
            blank_q <= 1'b0;
        end
    end

endmodule

// File: doc/row_scan_decoder.md
ROW_SCAN_DECODER -- requirements
Module: row_scan_decoder

Interface
REQ-001 SHALL have parameter N, default 3: select width; output count is 2**N.
REQ-002 SHALL have parameter COUNT, default 2**N: number of active scan positions; legal range 2..2**N.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port ena, input, 1: 1 enables the outputs; 0 forces out to zero.
REQ-006 SHALL have port mode, input, 1: 0 selects direct decode; 1 selects scan.
REQ-007 SHALL have port in, input, N: direct-mode select and scan-mode load value.
REQ-008 SHALL have port load, input, 1: scan-mode load strobe.
REQ-009 SHALL have port step, input, 1: scan-mode advance strobe, one advance per cycle high.
REQ-010 SHALL have port out, output, 2**N: registered one-hot (or all-zero) select.
REQ-011 SHALL have port index, output, N: registered current position.
REQ-012 SHALL have port wrap, output, 1: one-cycle pulse when the scan index wraps COUNT-1 -> 0.

Function
REQ-013 SHALL register out, index and wrap, with exactly 1 cycle from sampled inputs to outputs.
REQ-014 SHALL, while ena=0, drive out=0 and wrap=0 on the next cycle; index holds, and load/step are ignored.
REQ-015 SHALL, in DIRECT (ena=1, mode=0), set index<=in and out<=1<<in on the next cycle for any in, including in>=COUNT; wrap=0.
REQ-016 SHALL, in SCAN (ena=1, mode=1), apply load with priority over step.
REQ-017 SHALL, on load, set index<=in, or index<=0 when in>=COUNT; out<=1<<new index; wrap=0.
REQ-018 SHALL, on step without load, set index<=index+1, or index<=0 with wrap=1 when index==COUNT-1 (also when index>=COUNT, entered from DIRECT).
REQ-019 SHALL, in SCAN with neither load nor step, hold index and out and set wrap=0.
REQ-020 SHALL continue scanning from the current index on a DIRECT->SCAN switch, with no implicit reset.
REQ-021 SHALL keep out either all-zero or exactly one-hot and equal to 1<<index whenever nonzero.
REQ-022 SHALL, on an ena 0->1 transition, restore out=1<<index (DIRECT: 1<<in) on the next cycle.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, set index=0, out=0 and wrap=0, and clear any pending blank cycle.
REQ-024 SHALL give rst priority over ena, load and step; a rst in mid-scan or mid-blank discards all state.
REQ-025 SHALL resume normal operation on the first edge after rst deasserts.

Configuration
REQ-026 SHALL use macro ROW_SCAN_DECODER_BLANKING_EN for break-before-make blanking.
REQ-027 SHALL, with the macro defined, make each SCAN step that changes index drive out=0 for one cycle; index and wrap update in that cycle, and out=1<<index follows on the next cycle.
REQ-028 SHALL, with the macro defined, ignore a step arriving during the blank cycle (not queued); a load during blank takes effect normally and ends the blank.
REQ-029 SHALL, with the macro undefined, have no blank cycle, so out changes in the same cycle as index.

Verification (N=3, COUNT=6)
REQ-030 SHALL cover: rst, then DIRECT ena=1 with in=5 -> next cycle out=8'h20, index=5.
REQ-031 SHALL cover: SCAN load in=4, then step held 3 cycles -> index 5,0,1; wrap=1 only in the cycle index becomes 0.
REQ-032 SHALL cover: load and step in the same cycle with in=2 -> index=2, wrap=0; then load in=7 -> index=0.
REQ-033 SHALL cover: DIRECT in=7, then SCAN step -> index=0, wrap=1, out=8'h01.
REQ-034 SHALL cover: ena=0 mid-scan at index 3 with step high -> out=0 and index stays 3; ena=1 -> out=8'h08.
REQ-035 SHALL cover: with BLANKING_EN defined, step from index 1, step again during blank -> out 0 then 8'h04, index=2; without the macro, out=8'h04 immediately.
